mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: max cycles to wait for mem_ready before raising a bus fault.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port opcode  input  6  IR[31:26] of the currently latched instruction.
REQ-005 SHALL have port zero  input  1  ALU zero flag, sampled in BRANCH state.
REQ-006 SHALL have port mem_ready  input  1  memory completion handshake for the current read/write.
REQ-007 SHALL have port alu_src_a  output  1  0 = PC, 1 = register A.
REQ-008 SHALL have port alu_src_b  output  2  ALU B mux select: 00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-009 SHALL have port alu_op  output  2  00 add, 01 sub, 10 decode funct.
REQ-010 SHALL have ports pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, epc_write  output  1 each  standard multicycle datapath strobes.
REQ-011 SHALL have port pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector.
REQ-012 SHALL have port fault  output  1  one-cycle pulse on illegal opcode or memory timeout.

Function
REQ-013 SHALL implement a Moore FSM: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, EXCEPT.
REQ-014 FETCH SHALL assert mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write SHALL assert only in the cycle mem_ready=1, then go to DECODE.
REQ-015 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute) and dispatch on opcode: 0x00 EXEC_R, 0x08 EXEC_I, 0x23/0x2B MEM_ADDR, 0x04 BRANCH, 0x02 JUMP, any other EXCEPT.
REQ-016 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> R_WB (reg_write=1, reg_dst=1, mem_to_reg=0) -> FETCH.
REQ-017 EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00 -> I_WB (reg_write=1, reg_dst=0, mem_to_reg=0) -> FETCH.
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 -> MEM_RD if 0x23, MEM_WR if 0x2B.
REQ-019 MEM_RD/MEM_WR SHALL hold mem_read/mem_write with iord=1 until mem_ready=1; MEM_RD -> MEM_WB (reg_write=1, mem_to_reg=1, reg_dst=0) -> FETCH; MEM_WR -> FETCH.
REQ-020 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH; PC updates only if zero=1 (datapath ANDs).
REQ-021 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-022 EXCEPT: epc_write=1, pc_write=1, pc_source=11, fault=1 for exactly one cycle -> FETCH.
REQ-023 A wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR and increment each cycle mem_ready=0 there; reaching TIMEOUT-1 with mem_ready=0 SHALL go to EXCEPT; mem_ready=1 on that same cycle wins (normal progress).
REQ-024 Every strobe not listed for a state SHALL be 0; selects not listed SHALL be 00/0.
REQ-025 mem_read and mem_write SHALL never be asserted in the same cycle; reg_write and pc_write SHALL never both be 1.

Reset
REQ-026 reset_n=0 SHALL immediately force state FETCH, counter 0, fault 0, and all strobes deasserted except FETCH's Moore outputs after reset_n rises.
REQ-027 Reset mid-MEM_WR SHALL abort the write without any further mem_write assertion; next cycle after release is a fresh FETCH.

Structure
REQ-028 State enum, opcode constants (OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J) and ALU-B/PC-source codes SHALL live in shared package mc_ctrl_pkg.
REQ-029 Output decode SHALL be a combinational sub-module mc_ctrl_outdec (state -> strobes); mc_ctrl holds state register and wait counter.

Verification
REQ-030 Reset, mem_ready=1 always, opcode 0x00 -> FETCH, DECODE, EXEC_R (alu_src_b=00, alu_op=10), R_WB (reg_write=1, reg_dst=1), FETCH; 4 cycles per instruction.
REQ-031 opcode 0x23, mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles, then MEM_WB with mem_to_reg=1.
REQ-032 opcode 0x04, zero=0 then zero=1 -> pc_write_cond=1, pc_source=01, alu_op=01 in BRANCH both times.
REQ-033 opcode 0x3F -> DECODE then EXCEPT: fault, epc_write, pc_write=1, pc_source=11 for one cycle.
REQ-034 mem_ready held 0 in FETCH with TIMEOUT=16 -> EXCEPT after 16 FETCH cycles; mem_ready=1 on cycle 16 -> DECODE instead.
REQ-035 reset_n pulsed low during MEM_WR -> mem_write drops asynchronously, FETCH follows release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: state set,
// opcodes, mux select codes and the packed control-strobe bundle.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_EXEC_R,
        ST_R_WB,
        ST_EXEC_I,
        ST_I_WB,
        ST_BRANCH,
        ST_JUMP,
        ST_EXCEPT
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_EXC    = 2'b11;

    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       epc_write;
        logic [1:0] pc_source;
        logic       fault;
    } ctrl_t;

    // DECODE dispatch: unknown opcodes trap to EXCEPT
    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_R:         return ST_EXEC_R;
            OP_ADDI:      return ST_EXEC_I;
            OP_LW, OP_SW: return ST_MEM_ADDR;
            OP_BEQ:       return ST_BRANCH;
            OP_J:         return ST_JUMP;
            default:      return ST_EXCEPT;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> datapath strobe decode. Only FETCH looks at
// mem_ready, so IR/PC load exactly on the cycle the fetch completes.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        case (state)
            ST_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = ALUB_FOUR;
                ctrl_c.alu_op    = ALUOP_ADD;
                ctrl_c.pc_source = PCS_ALU;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl_c.alu_src_b = ALUB_IMM_SH2;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            ST_MEM_ADDR, ST_EXEC_I: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = ALUB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.iord      = 1'b1;
            end
            ST_EXEC_R: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = ALUB_REG;
                ctrl_c.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
            end
            ST_I_WB: begin
                ctrl_c.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_c.alu_src_a     = 1'b1;
                ctrl_c.alu_src_b     = ALUB_REG;
                ctrl_c.alu_op        = ALUOP_SUB;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_source     = PCS_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCS_JUMP;
            end
            ST_EXCEPT: begin
                ctrl_c.epc_write = 1'b1;
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = PCS_EXC;
                ctrl_c.fault     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle CPU control unit: state register, memory wait/timeout counter,
// and strobe decode via mc_ctrl_outdec.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       epc_write,
    output logic [1:0] pc_source,
    output logic       fault
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             at_limit;
    ctrl_t            dec_c;
    ctrl_t            ctrl;

    // zero is qualified against pc_write_cond in the datapath, not here
    logic unused_zero;
    assign unused_zero = zero;

    assign at_limit = (cnt == CNT_W'(TIMEOUT - 1));

    // Counter defaults to 0 so it is clear on every state entry; it only
    // advances while stalled in FETCH/MEM_RD/MEM_WR. mem_ready beats timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_FETCH;
            cnt   <= '0;
        end else begin
            cnt <= '0;
            case (state)
                ST_FETCH: begin
                    if (mem_ready)     state <= ST_DECODE;
                    else if (at_limit) state <= ST_EXCEPT;
                    else               cnt   <= cnt + CNT_W'(1);
                end
                ST_DECODE:   state <= dispatch(opcode);
                ST_MEM_ADDR: state <= (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD: begin
                    if (mem_ready)     state <= ST_MEM_WB;
                    else if (at_limit) state <= ST_EXCEPT;
                    else               cnt   <= cnt + CNT_W'(1);
                end
                ST_MEM_WR: begin
                    if (mem_ready)     state <= ST_FETCH;
                    else if (at_limit) state <= ST_EXCEPT;
                    else               cnt   <= cnt + CNT_W'(1);
                end
                ST_EXEC_R: state <= ST_R_WB;
                ST_EXEC_I: state <= ST_I_WB;
                default:   state <= ST_FETCH;
            endcase
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl_c    (dec_c)
    );

    // Strobes are held off while reset is asserted, so an in-flight write
    // is dropped immediately rather than at the next clock.
    assign ctrl = reset_n ? dec_c : '0;

    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign iord          = ctrl.iord;
    assign reg_write     = ctrl.reg_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign epc_write     = ctrl.epc_write;
    assign pc_source     = ctrl.pc_source;
    assign fault         = ctrl.fault;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: the driver queues the hand-derived strobe
// vector for each cycle, a negedge monitor pops and compares it.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord;
    logic       reg_write, reg_dst, mem_to_reg, epc_write;
    logic [1:0] pc_source;
    logic       fault;

    int checks = 0;
    int errors = 0;

    logic [17:0] exp_q[$];
    string       name_q[$];
    logic [17:0] obs;

    // {a, b[2], op[2], pcw, pcwc, irw, mr, mw, iord, rw, rd, m2r, epc, pcs[2], fault}
    localparam logic [17:0] E_ZERO     = 18'b0;
    localparam logic [17:0] E_FETCH_W  = {1'b0, 2'b01, 2'b00, 10'b0001000000, 2'b00, 1'b0};
    localparam logic [17:0] E_FETCH_G  = {1'b0, 2'b01, 2'b00, 10'b1011000000, 2'b00, 1'b0};
    localparam logic [17:0] E_DECODE   = {1'b0, 2'b11, 2'b00, 10'b0000000000, 2'b00, 1'b0};
    localparam logic [17:0] E_EXEC_R   = {1'b1, 2'b00, 2'b10, 10'b0000000000, 2'b00, 1'b0};
    localparam logic [17:0] E_R_WB     = {1'b0, 2'b00, 2'b00, 10'b0000001100, 2'b00, 1'b0};
    localparam logic [17:0] E_EXEC_I   = {1'b1, 2'b10, 2'b00, 10'b0000000000, 2'b00, 1'b0};
    localparam logic [17:0] E_I_WB     = {1'b0, 2'b00, 2'b00, 10'b0000001000, 2'b00, 1'b0};
    localparam logic [17:0] E_MEM_ADDR = {1'b1, 2'b10, 2'b00, 10'b0000000000, 2'b00, 1'b0};
    localparam logic [17:0] E_MEM_RD   = {1'b0, 2'b00, 2'b00, 10'b0001010000, 2'b00, 1'b0};
    localparam logic [17:0] E_MEM_WB   = {1'b0, 2'b00, 2'b00, 10'b0000001010, 2'b00, 1'b0};
    localparam logic [17:0] E_MEM_WR   = {1'b0, 2'b00, 2'b00, 10'b0000110000, 2'b00, 1'b0};
    localparam logic [17:0] E_BRANCH   = {1'b1, 2'b00, 2'b01, 10'b0100000000, 2'b01, 1'b0};
    localparam logic [17:0] E_JUMP     = {1'b0, 2'b00, 2'b00, 10'b1000000000, 2'b10, 1'b0};
    localparam logic [17:0] E_EXCEPT   = {1'b0, 2'b00, 2'b00, 10'b1000000001, 2'b11, 1'b1};

    mc_ctrl #(.TIMEOUT(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .ir_write      (ir_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .iord          (iord),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .epc_write     (epc_write),
        .pc_source     (pc_source),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    assign obs = {alu_src_a, alu_src_b, alu_op, pc_write, pc_write_cond, ir_write,
                  mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg,
                  epc_write, pc_source, fault};

    // Monitor: compare queued expectation plus the exclusivity invariants
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [17:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s: got %b expected %b (t=%0t)", n, obs, e, $time);
            end
        end
        checks++;
        if ((mem_read & mem_write) | (reg_write & pc_write)) begin
            errors++;
            $display("FAIL exclusive_strobes: rd=%b wr=%b rw=%b pcw=%b expected no overlap (t=%0t)",
                     mem_read, mem_write, reg_write, pc_write, $time);
        end
    end

    // Drive inputs for the current cycle, queue its expectation, advance
    task automatic step(input logic mr, input logic z, input logic [17:0] e, input string nm);
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        opcode    = 6'h00;
        zero      = 1'b0;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, E_ZERO, "reset_hold");
        step(1'b1, 1'b0, E_ZERO, "reset_hold2");
        reset_n = 1'b1;

        // R-type, 4 cycles with memory always ready
        opcode = 6'h00;
        step(1'b1, 1'b0, E_FETCH_G, "r_fetch");
        step(1'b1, 1'b0, E_DECODE,  "r_decode");
        step(1'b1, 1'b0, E_EXEC_R,  "r_exec");
        step(1'b1, 1'b0, E_R_WB,    "r_wb");

        // ADDI
        opcode = 6'h08;
        step(1'b1, 1'b0, E_FETCH_G, "i_fetch");
        step(1'b1, 1'b0, E_DECODE,  "i_decode");
        step(1'b1, 1'b0, E_EXEC_I,  "i_exec");
        step(1'b1, 1'b0, E_I_WB,    "i_wb");

        // LW with 3 stall cycles in MEM_RD
        opcode = 6'h23;
        step(1'b1, 1'b0, E_FETCH_G,  "lw_fetch");
        step(1'b1, 1'b0, E_DECODE,   "lw_decode");
        step(1'b1, 1'b0, E_MEM_ADDR, "lw_addr");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, E_MEM_RD, "lw_rd_wait");
        step(1'b1, 1'b0, E_MEM_RD,   "lw_rd_done");
        step(1'b1, 1'b0, E_MEM_WB,   "lw_wb");

        // SW with one stall
        opcode = 6'h2B;
        step(1'b1, 1'b0, E_FETCH_G,  "sw_fetch");
        step(1'b1, 1'b0, E_DECODE,   "sw_decode");
        step(1'b1, 1'b0, E_MEM_ADDR, "sw_addr");
        step(1'b0, 1'b0, E_MEM_WR,   "sw_wr_wait");
        step(1'b1, 1'b0, E_MEM_WR,   "sw_wr_done");

        // BEQ not taken then taken: controller outputs identical
        opcode = 6'h04;
        step(1'b1, 1'b0, E_FETCH_G, "beq0_fetch");
        step(1'b1, 1'b0, E_DECODE,  "beq0_decode");
        step(1'b1, 1'b0, E_BRANCH,  "beq0_branch");
        step(1'b1, 1'b1, E_FETCH_G, "beq1_fetch");
        step(1'b1, 1'b1, E_DECODE,  "beq1_decode");
        step(1'b1, 1'b1, E_BRANCH,  "beq1_branch");

        // J
        opcode = 6'h02;
        step(1'b1, 1'b0, E_FETCH_G, "j_fetch");
        step(1'b1, 1'b0, E_DECODE,  "j_decode");
        step(1'b1, 1'b0, E_JUMP,    "j_jump");

        // Illegal opcode
        opcode = 6'h3F;
        step(1'b1, 1'b0, E_FETCH_G, "ill_fetch");
        step(1'b1, 1'b0, E_DECODE,  "ill_decode");
        step(1'b1, 1'b0, E_EXCEPT,  "ill_except");

        // Fetch timeout: 16 stalled FETCH cycles then EXCEPT
        opcode = 6'h00;
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, E_FETCH_W, "to_fetch_wait");
        step(1'b0, 1'b0, E_EXCEPT, "to_except");

        // Ready on the 16th cycle wins over the timeout
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, E_FETCH_W, "edge_fetch_wait");
        step(1'b1, 1'b0, E_FETCH_G, "edge_fetch_ready");
        step(1'b1, 1'b0, E_DECODE,  "edge_decode");
        step(1'b1, 1'b0, E_EXEC_R,  "edge_exec");
        step(1'b1, 1'b0, E_R_WB,    "edge_wb");

        // MEM_RD timeout
        opcode = 6'h23;
        step(1'b1, 1'b0, E_FETCH_G,  "rdto_fetch");
        step(1'b1, 1'b0, E_DECODE,   "rdto_decode");
        step(1'b1, 1'b0, E_MEM_ADDR, "rdto_addr");
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, E_MEM_RD, "rdto_wait");
        step(1'b0, 1'b0, E_EXCEPT,   "rdto_except");

        // Reset asserted mid MEM_WR
        opcode = 6'h2B;
        step(1'b1, 1'b0, E_FETCH_G,  "rst_fetch");
        step(1'b1, 1'b0, E_DECODE,   "rst_decode");
        step(1'b1, 1'b0, E_MEM_ADDR, "rst_addr");
        step(1'b0, 1'b0, E_MEM_WR,   "rst_wr_wait");
        #3;
        reset_n = 1'b0;
        exp_q.push_back(E_ZERO);
        name_q.push_back("rst_mid_wr");
        @(posedge clk);
        #1;
        step(1'b0, 1'b0, E_ZERO, "rst_mid_hold");
        reset_n = 1'b1;
        step(1'b0, 1'b0, E_FETCH_W,  "rst_refetch_wait");
        step(1'b1, 1'b0, E_FETCH_G,  "rst_refetch");
        step(1'b1, 1'b0, E_DECODE,   "rst_decode2");
        step(1'b1, 1'b0, E_MEM_ADDR, "rst_addr2");
        step(1'b1, 1'b0, E_MEM_WR,   "rst_wr2");
        step(1'b1, 1'b0, E_FETCH_G,  "rst_final_fetch");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
